// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter between core writeback and debug loader, with a bank-clear walker.
// Optional grant statistics are built when REG_WRITE_ARBITER_STATS_EN is defined.
//
// state | meaning
// IDLE  | arbitrate req0/req1, accept clear_start
// CLEAR | walk index 1..NrOfRegs-1 writing zero, one step per Tick
module reg_write_arbiter #(
  parameter int NrOfBits = 32,
  parameter int NrOfRegs = 32,
  parameter int AddrBits = 5
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                req0_valid,
  input  logic [AddrBits-1:0] req0_addr,
  input  logic [NrOfBits-1:0] req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [AddrBits-1:0] req1_addr,
  input  logic [NrOfBits-1:0] req1_data,
  output logic                req1_ready,
  input  logic                clear_start,
  output logic                clear_busy,
  output logic [NrOfRegs-1:0] wr_en,
  output logic [NrOfBits-1:0] wr_data,
  output logic [15:0]         grant_cnt0,
  output logic [15:0]         grant_cnt1
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t              state;
  logic                prio;
  logic [AddrBits-1:0] clr_idx;
  logic                grant;
  logic                accept;
  logic [AddrBits-1:0] xfer_addr;
  logic [NrOfBits-1:0] xfer_data;

  // prio names the requester favoured when both are valid
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = prio;
  end

  assign accept     = !Reset && (state == IDLE) && Tick && !clear_start;
  assign req0_ready = accept && req0_valid && !grant;
  assign req1_ready = accept && req1_valid && grant;
  assign clear_busy = (state == CLEAR);
  assign xfer_addr  = grant ? req1_addr : req0_addr;
  assign xfer_data  = grant ? req1_data : req0_data;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      prio    <= 1'b0;
      clr_idx <= AddrBits'(1);
      wr_en   <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= '0;
      if (Tick) begin
        case (state)
          IDLE: begin
            if (clear_start) begin
              state   <= CLEAR;
              clr_idx <= AddrBits'(1);
            end else if (req0_ready || req1_ready) begin
              prio    <= req0_ready;
              wr_data <= xfer_data;
              // register 0 is hardwired zero: accept but never enable it
              if (xfer_addr != '0) wr_en <= NrOfRegs'(1) << xfer_addr;
            end
          end
          CLEAR: begin
            wr_en   <= NrOfRegs'(1) << clr_idx;
            wr_data <= '0;
            if (clr_idx == AddrBits'(NrOfRegs - 1)) begin
              state   <= IDLE;
              clr_idx <= AddrBits'(1);
            end else begin
              clr_idx <= clr_idx + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef REG_WRITE_ARBITER_STATS_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a negedge monitor models the handshake and
// queues expected bank writes, popping them one cycle after acceptance.
module tb_reg_write_arbiter;
  localparam int NB = 32;
  localparam int NR = 32;
  localparam int AB = 5;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Tick = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0, clear_start = 1'b0;
  logic [AB-1:0] req0_addr = '0, req1_addr = '0;
  logic [NB-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready, clear_busy;
  logic [NR-1:0] wr_en;
  logic [NB-1:0] wr_data;
  logic [15:0]   grant_cnt0, grant_cnt1;

  reg_write_arbiter #(.NrOfBits(NB), .NrOfRegs(NR), .AddrBits(AB)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .wr_en(wr_en), .wr_data(wr_data),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int            at;
    logic [NR-1:0] en;
    logic [NB-1:0] data;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic          m_clear, m_prio, m_e0, m_e1, m_g;
  int            m_idx;
  exp_t          m_ent;
  logic [AB-1:0] m_addr;

  always @(negedge Clock) begin
    if (Reset) begin
      q.delete();
      m_clear = 1'b0; m_prio = 1'b0; m_idx = 1;
      vectors++;
      if (wr_en !== '0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || clear_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: wr_en=%h r0=%b r1=%b busy=%b, required all 0",
                 wr_en, req0_ready, req1_ready, clear_busy);
      end
    end else begin
      vectors++;
      if (q.size() > 0 && q[0].at == cyc) begin
        m_ent = q.pop_front();
        if (wr_en !== m_ent.en || wr_data !== m_ent.data) begin
          miscompares++;
          $display("FAIL bank_write cyc %0d: wr_en=%h wr_data=%h, required %h %h",
                   cyc, wr_en, wr_data, m_ent.en, m_ent.data);
        end
      end else if (wr_en !== '0) begin
        miscompares++;
        $display("FAIL quiet_wr_en cyc %0d: wr_en=%h, required 0", cyc, wr_en);
      end
      m_e0 = 1'b0; m_e1 = 1'b0;
      if (!m_clear && Tick && !clear_start) begin
        m_g  = (req0_valid && req1_valid) ? m_prio : req1_valid;
        m_e0 = req0_valid && !m_g;
        m_e1 = req1_valid && m_g;
      end
      vectors++;
      if (req0_ready !== m_e0 || req1_ready !== m_e1 || clear_busy !== m_clear) begin
        miscompares++;
        $display("FAIL handshake cyc %0d: r0=%b r1=%b busy=%b, required %b %b %b",
                 cyc, req0_ready, req1_ready, clear_busy, m_e0, m_e1, m_clear);
      end
      if (Tick) begin
        if (!m_clear) begin
          if (clear_start) begin
            m_clear = 1'b1; m_idx = 1;
          end else if (m_e0 || m_e1) begin
            m_prio = m_e0;
            m_addr = m_e0 ? req0_addr : req1_addr;
            if (m_addr != '0) begin
              m_ent.at = cyc + 1; m_ent.en = 32'h1 << m_addr;
              m_ent.data = m_e0 ? req0_data : req1_data;
              q.push_back(m_ent);
            end
          end
        end else begin
          m_ent.at = cyc + 1; m_ent.en = 32'h1 << m_idx; m_ent.data = '0;
          q.push_back(m_ent);
          if (m_idx == NR - 1) begin m_clear = 1'b0; m_idx = 1; end
          else m_idx++;
        end
      end
    end
  end

  task automatic step(input logic v0, input logic [AB-1:0] a0, input logic [NB-1:0] d0,
                      input logic v1, input logic [AB-1:0] a1, input logic [NB-1:0] d1,
                      input logic cs, input logic tk);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    clear_start = cs; Tick = tk;
    @(posedge Clock); #1;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req0_addr = 5'd4; Tick = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b0 || wr_en !== '0 || wr_data !== '0 || clear_busy !== 1'b0 ||
        grant_cnt0 !== 16'h0 || grant_cnt1 !== 16'h0) begin
      miscompares++;
      $display("FAIL test_reset: r0=%b wr_en=%h wr_data=%h busy=%b c0=%h c1=%h, required all 0",
               req0_ready, wr_en, wr_data, clear_busy, grant_cnt0, grant_cnt1);
    end
    req0_valid = 1'b0; Tick = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF; Tick = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ready: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
    end
    @(posedge Clock); #1;
    req0_valid = 1'b0;
    vectors++;
    if (wr_en !== 32'h20 || wr_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_write: wr_en=%h wr_data=%h, required 00000020 deadbeef", wr_en, wr_data);
    end
    @(posedge Clock); #1;
    vectors++;
    if (wr_en !== '0) begin
      miscompares++;
      $display("FAIL single_pulse_len: wr_en=%h, required 0", wr_en);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_round_robin();
    logic [1:0] want [4];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_addr = AB'(i + 1);  req0_data = 32'h1000 + i;
      req1_valid = 1'b1; req1_addr = AB'(i + 10); req1_data = 32'h2000 + i;
      clear_start = 1'b0; Tick = 1'b1;
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== want[i]) begin
        miscompares++;
        $display("FAIL rr_grant %0d: {r1,r0}=%b, required %b", i, {req1_ready, req0_ready}, want[i]);
      end
      @(posedge Clock); #1;
    end
    step(0, 0, 0, 0, 0, 0, 0, 1);
    vectors++;
`ifdef REG_WRITE_ARBITER_STATS_EN
    if (grant_cnt0 !== 16'd2 || grant_cnt1 !== 16'd2) begin
      miscompares++;
      $display("FAIL rr_counts: c0=%0d c1=%0d, required 2 2", grant_cnt0, grant_cnt1);
    end
`else
    if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) begin
      miscompares++;
      $display("FAIL rr_counts: c0=%0d c1=%0d, required 0 0", grant_cnt0, grant_cnt1);
    end
`endif
  endtask

  task automatic test_addr0_tick();
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h12345678; Tick = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL addr0_ready: r0=%b, required 1", req0_ready);
    end
    @(posedge Clock); #1;
    req0_addr = 5'd7; Tick = 1'b0;
    #1;
    vectors++;
    if (wr_en !== '0 || req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL addr0_tick0: wr_en=%h r0=%b, required 0 0", wr_en, req0_ready);
    end
    @(posedge Clock); #1;
    vectors++;
    if (wr_en !== '0) begin
      miscompares++;
      $display("FAIL tick0_no_write: wr_en=%h, required 0", wr_en);
    end
    // both valid after req0 was last granted: req1 must win
    step(1, 5'd2, 32'hA, 1, 5'd3, 32'hB, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_clear();
    int n = 0;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hCAFEF00D;
    req1_valid = 1'b0; clear_start = 1'b1; Tick = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_prio: r0=%b, required 0", req0_ready);
    end
    @(posedge Clock); #1;
    while (clear_busy === 1'b1 && n < 40) begin
      n++;
      clear_start = (n == 5);
      @(posedge Clock); #1;
    end
    clear_start = 1'b0;
    vectors++;
    if (n != 31) begin
      miscompares++;
      $display("FAIL clear_length: busy cycles=%0d, required 31", n);
    end
    vectors++;
    if (req0_ready !== 1'b1 || wr_en !== 32'h80000000) begin
      miscompares++;
      $display("FAIL clear_exit: r0=%b wr_en=%h, required 1 80000000", req0_ready, wr_en);
    end
    @(posedge Clock); #1;
    req0_valid = 1'b0;
    vectors++;
    if (wr_en !== 32'h200 || wr_data !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL clear_then_req: wr_en=%h wr_data=%h, required 00000200 cafef00d", wr_en, wr_data);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_abort();
    int i = 0;
    int pulses = 0;
    step(0, 0, 0, 0, 0, 0, 1, 1);
    while (wr_en !== 32'h400 && i < 20) begin
      i++;
      step(0, 0, 0, 0, 0, 0, 0, (i != 3));
    end
    vectors++;
    if (wr_en !== 32'h400) begin
      miscompares++;
      $display("FAIL abort_reach_step10: wr_en=%h, required 00000400", wr_en);
    end
    Reset = 1'b1;
    #1;
    vectors++;
    if (wr_en !== '0 || clear_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_immediate: wr_en=%h busy=%b, required 0 0", wr_en, clear_busy);
    end
    @(posedge Clock); #1;
    Reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1);
      if (wr_en !== '0 || clear_busy !== 1'b0) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL abort_no_pulses: active cycles=%0d, required 0", pulses);
    end
  endtask

  task automatic test_stats();
    do_reset();
`ifdef REG_WRITE_ARBITER_STATS_EN
    for (int k = 0; k < 70000; k++) step(0, 0, 0, 1, 5'd3, 32'(k), 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    vectors++;
    if (grant_cnt1 !== 16'hFFFF || grant_cnt0 !== 16'h0) begin
      miscompares++;
      $display("FAIL stats_saturate: c0=%h c1=%h, required 0000 ffff", grant_cnt0, grant_cnt1);
    end
`else
    for (int k = 0; k < 20; k++) step(0, 0, 0, 1, 5'd3, 32'(k), 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    vectors++;
    if (grant_cnt1 !== 16'h0 || grant_cnt0 !== 16'h0) begin
      miscompares++;
      $display("FAIL stats_disabled: c0=%h c1=%h, required 0000 0000", grant_cnt0, grant_cnt1);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge Clock); #1;
    test_reset();
    test_single();
    test_round_robin();
    test_addr0_tick();
    test_clear();
    test_reset_abort();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter NrOfBits, default 32: data width of the shared register bank.
REQ-002 SHALL have parameter NrOfRegs, default 32: register count, power of two, 4..32.
REQ-003 SHALL have parameter AddrBits, default 5: equals log2(NrOfRegs).
REQ-004 SHALL have port Clock, input, 1: clock; all state changes occur on its rising edge.
REQ-005 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port Tick, input, 1: global advance enable; no state change or handshake occurs when Tick=0.
REQ-007 SHALL have port req0_valid, input, 1: core writeback request.
REQ-008 SHALL have port req0_addr, input, AddrBits: core target register.
REQ-009 SHALL have port req0_data, input, NrOfBits: core write data.
REQ-010 SHALL have port req0_ready, output, 1: core request accepted this cycle.
REQ-011 SHALL have ports req1_valid, req1_addr, req1_data and req1_ready, identical to the req0 ports, for the debug loader.
REQ-012 SHALL have port clear_start, input, 1: start a bank clear.
REQ-013 SHALL have port clear_busy, output, 1: a clear sequence is in progress.
REQ-014 SHALL have port wr_en, output, NrOfRegs: one-hot ClockEnable to the bank registers.
REQ-015 SHALL have port wr_data, output, NrOfBits: D value to the bank registers.
REQ-016 SHALL have ports grant_cnt0 and grant_cnt1, output, 16 each: acceptance statistics.

Function
REQ-017 SHALL implement states IDLE and CLEAR.
REQ-018 In IDLE with Tick=1, a transfer SHALL occur for requester n when reqn_valid=1 and reqn_ready=1.
REQ-019 reqn_ready SHALL be combinational: 1 only when state=IDLE, Tick=1, clear_start=0, reqn_valid=1 and n holds the grant.
REQ-020 With a single valid requester, that requester SHALL hold the grant.
REQ-021 With both requesters valid, the grant SHALL go to the requester not granted last (round-robin pointer); the pointer SHALL update only on a transfer.
REQ-022 At most one ready SHALL be asserted per cycle.
REQ-023 A transfer SHALL register wr_en = one-hot(addr) and wr_data = data, visible the cycle after acceptance (latency 1) and held for exactly one cycle.
REQ-024 In cycles without a transfer, wr_en SHALL be all zero and wr_data SHALL hold its last value.
REQ-025 A transfer to address 0 SHALL be accepted (ready=1, pointer updates) but SHALL produce wr_en all zero; register 0 is constant zero.
REQ-026 In IDLE with Tick=1, clear_start=1 SHALL enter CLEAR, taking priority over any valid request; no ready is asserted that cycle.
REQ-027 CLEAR SHALL step an index from 1 to NrOfRegs-1, advancing once per Tick=1 cycle, registering wr_en = one-hot(index) and wr_data = 0 each step.
REQ-028 After the step for NrOfRegs-1, the block SHALL return to IDLE; the clear spans NrOfRegs-1 Tick cycles.
REQ-029 clear_busy SHALL equal (state==CLEAR); both readies SHALL be 0 during CLEAR.
REQ-030 clear_start asserted while in CLEAR SHALL be ignored; the sequence is not restarted.
REQ-031 Tick=0 during CLEAR SHALL freeze the index, and wr_en SHALL be 0 for that cycle.

Reset
REQ-032 Reset SHALL asynchronously force state=IDLE, the round-robin pointer to favour requester 0, wr_en=0, wr_data=0, clear index=1, and grant counters=0.
REQ-033 Reset asserted mid-CLEAR SHALL abort the sequence; no further wr_en pulses SHALL occur until a new request or clear.
REQ-034 Readies SHALL be 0 while Reset=1.

Configuration
REQ-035 The macro REG_WRITE_ARBITER_STATS_EN SHALL control the grant statistics.
REQ-036 With REG_WRITE_ARBITER_STATS_EN defined, grant_cntn SHALL increment on each requester-n transfer and saturate at 16'hFFFF.
REQ-037 Without REG_WRITE_ARBITER_STATS_EN, grant_cnt0 and grant_cnt1 SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-038 Only req0 valid, addr=5, data=32'hDEADBEEF, Tick=1 -> req0_ready=1 that cycle; next cycle wr_en=32'h20 and wr_data=32'hDEADBEEF; the cycle after, wr_en=0.
REQ-039 Both requesters valid for 4 cycles after reset -> grants 0,1,0,1; grant_cnt0=2 and grant_cnt1=2 (stats enabled).
REQ-040 clear_start and req0_valid in the same cycle -> no ready; clear_busy=1 for 31 cycles; wr_en walks 32'h2 .. 32'h80000000 with wr_data=0; req0 is accepted on the first IDLE cycle.
REQ-041 Transfer to addr 0 -> ready=1 and wr_en stays 0; Tick=0 with valid held -> no ready and no wr_en.
REQ-042 Reset asserted at clear step 10 -> wr_en=0 and clear_busy=0 immediately; no pulses after release.
REQ-043 70000 req1 transfers with stats enabled -> grant_cnt1=16'hFFFF; with the macro undefined -> grant_cnt1=0.
